// File: rtl/sw_debounce_pkg.sv
// Shared constants and helpers for the switch debounce block.
//   SW_WIDTH             - number of slide switches on the board
//   DEFAULT_TICK_CYCLES  - clk cycles per sample tick (1 ms at 100 MHz)
//   DEFAULT_STABLE_TICKS - ticks a new level must persist before acceptance
//   clog2()              - ceil(log2(value)), used to size counters
package sw_debounce_pkg;

    localparam int unsigned SW_WIDTH             = 16;
    localparam int unsigned DEFAULT_TICK_CYCLES  = 100_000;
    localparam int unsigned DEFAULT_STABLE_TICKS = 10;

    // Smallest r with 2**r >= value; 0 for value <= 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sw_debounce_if.sv
// Switch-conditioning bus between the raw pins and downstream control logic.
//   sw_raw  - raw asynchronous switch levels (driven by master)
//   sw_db   - debounced levels
//   sw_rise - one-cycle 0->1 event per bit
//   sw_fall - one-cycle 1->0 event per bit
//   tick    - one-cycle sample strobe
// master: the pin/stimulus side; slave: the debouncer.
interface sw_debounce_if
    import sw_debounce_pkg::*;
#(
    parameter int unsigned WIDTH = SW_WIDTH
);

    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_db;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             tick;

    modport master (
        output sw_raw,
        input  sw_db,
        input  sw_rise,
        input  sw_fall,
        input  tick
    );

    modport slave (
        input  sw_raw,
        output sw_db,
        output sw_rise,
        output sw_fall,
        output tick
    );

endinterface

// File: rtl/sw_debounce_bit.sv
// Single-bit synchronizer and debouncer.
//   clk, rst_n - clock and synchronous active-low reset
//   tick       - shared sample strobe
//   sw_raw     - raw asynchronous switch pin
//   sw_db      - accepted (debounced) level, registered
//   sw_rise    - one-cycle pulse in the cycle sw_db goes 0->1
//   sw_fall    - one-cycle pulse in the cycle sw_db goes 1->0
module sw_debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = DEFAULT_STABLE_TICKS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic sw_raw,
    output logic sw_db,
    output logic sw_rise,
    output logic sw_fall
);

    localparam int unsigned CNT_W = clog2(STABLE_TICKS + 1);

    logic             sync_q1;
    logic             sync_q2;
    logic             db_q;
    logic             rise_q;
    logic             fall_q;
    logic [CNT_W-1:0] cnt;

    logic             db_nxt;
    logic             rise_nxt;
    logic             fall_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    // Two-flop synchronizer for the asynchronous pin.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= sw_raw;
            sync_q2 <= sync_q1;
        end
    end

    // Qualification: any return to the accepted level restarts the count;
    // the count is cleared on acceptance, so it never wraps.
    always_comb begin
        cnt_nxt  = cnt;
        db_nxt   = db_q;
        rise_nxt = 1'b0;
        fall_nxt = 1'b0;
        if (sync_q2 == db_q) begin
            cnt_nxt = '0;
        end else if (tick && (cnt == CNT_W'(STABLE_TICKS - 1))) begin
            cnt_nxt  = '0;
            db_nxt   = sync_q2;
            rise_nxt = sync_q2;
            fall_nxt = ~sync_q2;
        end else if (tick) begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    // Debounce state and event registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            db_q   <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            db_q   <= db_nxt;
            rise_q <= rise_nxt;
            fall_q <= fall_nxt;
        end
    end

    assign sw_db   = db_q;
    assign sw_rise = rise_q;
    assign sw_fall = fall_q;

endmodule

// File: rtl/sw_debounce.sv
// Slide-switch conditioning: synchronizes and debounces each switch bit and
// emits rise/fall events; sw_db feeds the switch-gated LED PWM stage.
//   clk, rst_n - clock and synchronous active-low reset
//   bus        - sw_debounce_if slave: sw_raw in; sw_db, sw_rise, sw_fall,
//                tick out
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int unsigned WIDTH        = SW_WIDTH,
    parameter int unsigned TICK_CYCLES  = DEFAULT_TICK_CYCLES,
    parameter int unsigned STABLE_TICKS = DEFAULT_STABLE_TICKS
) (
    input  logic          clk,
    input  logic          rst_n,
    sw_debounce_if.slave  bus
);

    localparam int unsigned TICK_W = clog2(TICK_CYCLES);

    logic [TICK_W-1:0] tick_cnt;
    logic              tick_q;

    // Shared prescaler: tick is high in the cycle after the terminal count,
    // giving exactly one strobe every TICK_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            tick_q   <= 1'b0;
        end else if (tick_cnt == TICK_W'(TICK_CYCLES - 1)) begin
            tick_cnt <= '0;
            tick_q   <= 1'b1;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
            tick_q   <= 1'b0;
        end
    end

    assign bus.tick = tick_q;

    // One independent debouncer per switch bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_bit #(
            .STABLE_TICKS (STABLE_TICKS)
        ) u_bit (
            .clk     (clk),
            .rst_n   (rst_n),
            .tick    (tick_q),
            .sw_raw  (bus.sw_raw[i]),
            .sw_db   (bus.sw_db[i]),
            .sw_rise (bus.sw_rise[i]),
            .sw_fall (bus.sw_fall[i])
        );
    end

endmodule

// File: tb/tb_sw_debounce.sv
// Directed self-checking bench for sw_debounce (TICK_CYCLES=4, STABLE_TICKS=3).
module tb_sw_debounce;

    localparam int unsigned W            = 16;
    localparam int unsigned TICK_CYCLES  = 4;
    localparam int unsigned STABLE_TICKS = 3;

    logic clk = 1'b0;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sw_debounce_if #(.WIDTH(W)) bus ();

    sw_debounce #(
        .WIDTH        (W),
        .TICK_CYCLES  (TICK_CYCLES),
        .STABLE_TICKS (STABLE_TICKS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        bit  found;
        int  rises;

        // 1. Reset with all switches high; outputs must stay clear.
        rst_n      = 1'b0;
        bus.sw_raw = 16'hFFFF;
        repeat (5) step();
        check("rst_db",   32'(bus.sw_db),   32'h0);
        check("rst_rise", 32'(bus.sw_rise), 32'h0);
        check("rst_fall", 32'(bus.sw_fall), 32'h0);
        check("rst_tick", 32'(bus.tick),    32'h0);

        // Release; tick first after 4 cycles, then every 4.
        rst_n      = 1'b1;
        bus.sw_raw = 16'h0000;
        for (int k = 1; k <= 12; k++) begin
            step();
            check("tick_phase", 32'(bus.tick), 32'((k % 4) == 0));
        end

        // 2. Clean rise of bit 3. Input set just after the edge that raised tick:
        //    sync after 2 edges, ticks counted at edges 5, 9, accepted at 13.
        bus.sw_raw = 16'h0008;
        lat   = 0;
        found = 1'b0;
        for (int c = 1; c <= 20 && !found; c++) begin
            step();
            if (bus.sw_db != 16'h0000) begin
                found = 1'b1;
                lat   = c;
            end
        end
        check("rise_latency", 32'(lat),          32'd13);
        check("rise_db",      32'(bus.sw_db),    32'h0008);
        check("rise_pulse",   32'(bus.sw_rise),  32'h0008);
        check("rise_nofall",  32'(bus.sw_fall),  32'h0);
        step();
        check("rise_onecyc",  32'(bus.sw_rise),  32'h0);

        // 3. Bounce on bit 0 (3-cycle half periods) must never qualify.
        for (int p = 0; p < 8; p++) begin
            bus.sw_raw = ((p % 2) == 0) ? 16'h0009 : 16'h0008;
            repeat (3) begin
                step();
                check("bounce", {bus.sw_db, bus.sw_rise | bus.sw_fall}, {16'h0008, 16'h0000});
            end
        end
        bus.sw_raw = 16'h0008;
        repeat (16) begin
            step();
            check("bounce_hold", {bus.sw_db, bus.sw_rise | bus.sw_fall}, {16'h0008, 16'h0000});
        end

        // 4. Bring sw_db to 00FF, then swap to FF00 in a single cycle.
        bus.sw_raw = 16'h00FF;
        found = 1'b0;
        for (int c = 1; c <= 20 && !found; c++) begin
            step();
            if (bus.sw_db != 16'h0008) found = 1'b1;
        end
        check("lo_db",   32'(bus.sw_db),   32'h00FF);
        check("lo_rise", 32'(bus.sw_rise), 32'h00F7);
        check("lo_fall", 32'(bus.sw_fall), 32'h0);
        repeat (4) step();
        bus.sw_raw = 16'hFF00;
        found = 1'b0;
        for (int c = 1; c <= 20 && !found; c++) begin
            step();
            if (bus.sw_db != 16'h00FF) found = 1'b1;
        end
        check("swap_db",   32'(bus.sw_db),   32'hFF00);
        check("swap_fall", 32'(bus.sw_fall), 32'h00FF);
        check("swap_rise", 32'(bus.sw_rise), 32'hFF00);
        step();
        check("swap_onecyc", 32'(bus.sw_rise | bus.sw_fall), 32'h0);

        // 5. Reset in the middle of qualifying bit 0.
        rst_n      = 1'b0;
        bus.sw_raw = 16'h0000;
        repeat (2) step();
        check("mid_rst_db", 32'(bus.sw_db), 32'h0);
        rst_n      = 1'b1;
        bus.sw_raw = 16'h0001;
        repeat (9) step();
        check("mid_pre_db", 32'(bus.sw_db), 32'h0);
        rst_n = 1'b0;
        step();
        check("mid_in_rst", 32'(bus.sw_db | bus.sw_rise | bus.sw_fall), 32'h0);
        // After release: sync at edge 2, ticks counted at 5, 9, accepted at 13.
        rst_n = 1'b1;
        lat   = 0;
        found = 1'b0;
        for (int c = 1; c <= 20 && !found; c++) begin
            step();
            if (bus.sw_db[0]) begin
                found = 1'b1;
                lat   = c;
            end
        end
        check("mid_latency", 32'(lat),         32'd13);
        check("mid_rise",    32'(bus.sw_rise), 32'h0001);
        rises = 0;
        repeat (20) begin
            step();
            rises += int'(bus.sw_rise[0]);
        end
        check("mid_extra_rises", 32'(rises), 32'd0);
        check("mid_db_final",    32'(bus.sw_db), 32'h0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
